// File: rtl/accel_frame_uart_tx.sv
// Captures X/Y/Z samples, converts each to sign + 4 ASCII digits and
// sends the 22-byte "X+dddd Y+dddd Z+dddd\r\n" frame as 8N1 UART.
module accel_frame_uart_tx #(
  parameter int DATA_W       = 14,
  parameter int CLKS_PER_BIT = 434,
  parameter int DROP_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_stb,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] z_in,
  output logic              txd,
  output logic              busy,
  output logic              frame_done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int MW = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic txd_q, txd_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [MW-1:0] rem_q, rem_d;
  logic [1:0] axis_q, axis_d;
  logic [1:0] pos_q, pos_d;
  logic [11:0][3:0] dig_q, dig_d;

  logic [21:0][7:0] frame;
  logic [2:0] neg;
  logic [MW-1:0] wt;
  logic [DATA_W-1:0] axsel;
  logic accept;
  logic cnt_end;

  // Held one bit wider so the most negative sample keeps its magnitude.
  function automatic logic [MW-1:0] mag(input logic [DATA_W-1:0] s);
    logic [MW-1:0] e;
    e = {s[DATA_W-1], s};
    return s[DATA_W-1] ? (~e + 1'b1) : e;
  endfunction

  always_comb begin
    neg = {z_q[DATA_W-1], y_q[DATA_W-1], x_q[DATA_W-1]};
    frame = '0;
    for (int a = 0; a < 3; a++) begin
      frame[7*a]   = 8'h58 + 8'(a);
      frame[7*a+1] = neg[a] ? 8'h2D : 8'h2B;
      for (int p = 0; p < 4; p++) begin
        frame[7*a+2+p] = {4'h3, dig_q[4*a+p]};
      end
    end
    frame[6]  = 8'h20;
    frame[13] = 8'h20;
    frame[20] = 8'h0D;
    frame[21] = 8'h0A;
  end

  always_comb begin
    wt = MW'(10);
    unique case (1'b1)
      (pos_q == 2'd0): wt = MW'(1000);
      (pos_q == 2'd1): wt = MW'(100);
      default:         wt = MW'(10);
    endcase
    axsel = z_q;
    if (axis_q == 2'd0) axsel = x_q;
    else if (axis_q == 2'd1) axsel = y_q;
  end

  assign accept  = sample_stb & ~busy_q;
  assign cnt_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    rem_d   = rem_q;
    axis_d  = axis_q;
    pos_d   = pos_q;
    dig_d   = dig_q;

    if (accept) busy_d = 1'b1;
    else if (done_q) busy_d = 1'b0;

    if (sample_stb && busy_q && (drop_q != '1)) drop_d = drop_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          rem_d   = '0;
          axis_d  = 2'd0;
          pos_d   = 2'd3;
          dig_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // pos 3 is the per-axis load step before the 1000/100/10 passes.
        if (pos_q == 2'd3) begin
          rem_d = mag(axsel);
          pos_d = 2'd0;
        end else if (rem_q >= wt) begin
          rem_d = rem_q - wt;
          dig_d[{axis_q, pos_q}] = dig_q[{axis_q, pos_q}] + 4'd1;
        end else if (pos_q != 2'd2) begin
          pos_d = pos_q + 1'b1;
        end else begin
          dig_d[{axis_q, 2'd3}] = rem_q[3:0];
          pos_d = 2'd3;
          if (axis_q == 2'd2) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            axis_d = axis_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        sh_d    = frame[idx_q];
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          sh_d  = {1'b1, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (idx_q == 5'd21) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // txd follows the next state so it is registered alongside it.
    txd_d = 1'b1;
    if (state_d == S_START) txd_d = 1'b0;
    else if (state_d == S_DATA) txd_d = sh_d[0];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      rem_q   <= '0;
      axis_q  <= '0;
      pos_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      rem_q   <= rem_d;
      axis_q  <= axis_d;
      pos_q   <= pos_d;
      dig_q   <= dig_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_accel_frame_uart_tx.sv
// Directed bench: frames decoded by a UART monitor sampling every
// cycle of each 4-cycle bit, compared to hand-written strings.
`timescale 1ns/1ps
module tb_accel_frame_uart_tx;

  localparam int DW  = 14;
  localparam int CPB = 4;
  localparam int DRW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic [DW-1:0] x = '0;
  logic [DW-1:0] y = '0;
  logic [DW-1:0] z = '0;
  logic txd;
  logic busy;
  logic frame_done;
  logic [DRW-1:0] drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  logic [7:0] rx [22];

  always #5 clk = ~clk;

  accel_frame_uart_tx #(
    .DATA_W(DW),
    .CLKS_PER_BIT(CPB),
    .DROP_W(DRW)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .sample_stb(stb),
    .x_in(x),
    .y_in(y),
    .z_in(z),
    .txd(txd),
    .busy(busy),
    .frame_done(frame_done),
    .drop_cnt(drop_cnt)
  );

  always @(posedge clk)
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic send(input int xv, input int yv, input int zv);
    x = xv[DW-1:0];
    y = yv[DW-1:0];
    z = zv[DW-1:0];
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic recv_byte(input int bound, output logic [7:0] b,
                           output int lat);
    logic [9:0] bits;
    logic stable;
    logic v;
    lat = 0;
    b = '0;
    bits = '0;
    while (txd !== 1'b0 && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    chk("start_seen", txd, 0);
    if (txd !== 1'b0) return;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        v = txd;
        if (j == 0) bits[k] = v;
        else if (v !== bits[k]) stable = 1'b0;
      end
    end
    chk("bit_shape", {stable, bits[0], bits[9]}, 3'b101);
    b = bits[8:1];
  endtask

  task automatic recv_frame(input string ref_s, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      recv_byte((i == 0) ? 200 : 3, rx[i], lat);
      if (i == 0) chk("start_lat_le102", lat <= 102, 1);
      else chk("byte_gap", lat <= 2, 1);
      chk($sformatf("byte%0d", i), rx[i], ref_s[i]);
    end
  endtask

  task automatic end_frame(input logic stb_done, input int drop_pre,
                           input int drop_post, input int fd_exp);
    @(negedge clk);
    chk("frame_done", frame_done, 1);
    chk("busy_at_done", busy, 1);
    chk("drop_pre", drop_cnt, drop_pre);
    stb = stb_done;
    @(negedge clk);
    stb = 1'b0;
    chk("frame_done_off", frame_done, 0);
    chk("busy_fell", busy, 0);
    chk("drop_post", drop_cnt, drop_post);
    chk("fd_cnt", fd_cnt, fd_exp);
    chk("txd_idle", txd, 1);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_txd", txd, 1);
    chk("idle_busy", busy, 0);

    send(100, -1, 8191);
    fork
      recv_frame("X+0100 Y-0001 Z+8191\r\n", 22);
      begin
        repeat (48) @(negedge clk);
        x = 14'h1555;
        y = '0;
        z = '0;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
      end
    join
    end_frame(1'b1, 1, 2, 1);

    repeat (3) @(negedge clk);
    send(-8192, 0, -10);
    recv_frame("X-8192 Y+0000 Z-0010\r\n", 22);
    end_frame(1'b0, 2, 2, 2);

    send(-1234, 567, 9);
    fork
      recv_frame("X-1234 Y+0567 Z+0009\r\n", 22);
      begin
        for (int i = 0; i < 300; i++) begin
          stb = 1'b1;
          x = 14'($urandom);
          y = 14'($urandom);
          z = 14'($urandom);
          @(negedge clk);
        end
        stb = 1'b0;
      end
    join
    end_frame(1'b0, 255, 255, 3);
    repeat (20) @(negedge clk);
    chk("drop_hold", drop_cnt, 255);

    send(1234, -567, -8191);
    recv_frame("X+1234 Y-0567 Z-8191\r\n", 5);
    w = 0;
    while (txd !== 1'b0 && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("b5_start", txd, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd", txd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_drop", drop_cnt, 0);
    chk("abort_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_txd", txd, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fd", fd_cnt, 3);

    send(2047, -2048, 0);
    recv_frame("X+2047 Y-2048 Z+0000\r\n", 22);
    end_frame(1'b0, 0, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
